// File: rtl/d_ff.sv
// Parameterised D flip-flop with synchronous active-low reset and complement output.
// Optional clock enable port en is added when D_FF_ENABLE_EN is defined.
`timescale 1ns/1ps

module d_ff #(
    parameter int unsigned          WIDTH       = 1,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    input  logic [WIDTH-1:0] d,
    input  logic             clock,
    input  logic             rst_n
`ifdef D_FF_ENABLE_EN
    ,
    input  logic             en
`endif
);

    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q;
`ifdef D_FF_ENABLE_EN
        if (en) begin
            q_d = d;
        end
`else
        q_d = d;
`endif
    end

    // Reset is sampled on the edge only, so it has priority over enable and capture.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else begin
            q <= q_d;
        end
    end

    assign nq = ~q;

endmodule

// File: tb/tb_d_ff.sv
// Directed bench for d_ff: a 1-bit instance on the reference timeline and an 8-bit
// instance with RESET_VALUE 8'hA5; expected values go through a scoreboard queue.
`timescale 1ns/1ps

module tb_d_ff;

    logic       clock;
    logic       rst_n;
    logic       d1;
    logic       q1;
    logic       nq1;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] nq8;
`ifdef D_FF_ENABLE_EN
    logic       en1;
    logic       en8;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic       exp1_q[$];
    logic [7:0] exp8_q[$];

    d_ff #(
        .WIDTH       (1),
        .RESET_VALUE (1'b0)
    ) u_ff1 (
        .q     (q1),
        .nq    (nq1),
        .d     (d1),
        .clock (clock),
        .rst_n (rst_n)
`ifdef D_FF_ENABLE_EN
        ,
        .en    (en1)
`endif
    );

    d_ff #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_ff8 (
        .q     (q8),
        .nq    (nq8),
        .d     (d8),
        .clock (clock),
        .rst_n (rst_n)
`ifdef D_FF_ENABLE_EN
        ,
        .en    (en8)
`endif
    );

    // Rising edges at 10, 30, 50, ... ns.
    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    task automatic wait_until(input int t);
        if ($time < t) #(t - $time);
    endtask

    task automatic push1(input logic v);
        exp1_q.push_back(v);
    endtask

    task automatic push8(input logic [7:0] v);
        exp8_q.push_back(v);
    endtask

    task automatic check1(input string tag);
        logic e;
        n_tests++;
        if (exp1_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, q=%b", tag, q1);
        end else begin
            e = exp1_q.pop_front();
            assert (q1 === e && nq1 === ~e) else begin
                n_fail++;
                $error("FAIL %s: q=%b nq=%b, expected q=%b nq=%b", tag, q1, nq1, e, ~e);
            end
        end
    endtask

    task automatic check8(input string tag);
        logic [7:0] e;
        n_tests++;
        if (exp8_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, q=%h", tag, q8);
        end else begin
            e = exp8_q.pop_front();
            assert (q8 === e && nq8 === ~e) else begin
                n_fail++;
                $error("FAIL %s: q=%h nq=%h, expected q=%h nq=%h", tag, q8, nq8, e, ~e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        d1    = 1'b0;
        d8    = 8'h00;
`ifdef D_FF_ENABLE_EN
        en1   = 1'b1;
        en8   = 1'b1;
`endif

        // Reset edge at 10 ns with d=1 on the narrow flop.
        wait_until(5);
        d1 = 1'b1;
        d8 = 8'hFF;
        push1(1'b0);
        push8(8'hA5);
        wait_until(11);
        check1("reset_q1");
        check8("reset_q8");

        wait_until(15);
        rst_n = 1'b1;
        d8    = 8'h3C;
`ifdef D_FF_ENABLE_EN
        en8   = 1'b0;
`endif
        push1(1'b0);
        wait_until(20);
        check1("hold_after_deassert");

        // d falls in the same timestep as the 30 ns edge: the pre-edge 1 is captured.
        wait_until(30);
        d1 <= 1'b0;
        push1(1'b1);
`ifdef D_FF_ENABLE_EN
        push8(8'hA5);
`else
        push8(8'h3C);
`endif
        wait_until(31);
        check1("coincident_30");
        check8("capture8_30");

        push1(1'b0);
`ifdef D_FF_ENABLE_EN
        push8(8'hA5);
`endif
        wait_until(51);
        check1("capture_50");
`ifdef D_FF_ENABLE_EN
        check8("en_off_50");
`endif

        // Pulse entirely between the 50 and 70 ns edges.
        wait_until(55);
        d1 = 1'b1;
        wait_until(65);
        d1 = 1'b0;
        push1(1'b0);
`ifdef D_FF_ENABLE_EN
        push8(8'hA5);
`endif
        wait_until(71);
        check1("glitch_70");
`ifdef D_FF_ENABLE_EN
        check8("en_off_70");
`endif

        wait_until(75);
        d1 = 1'b1;
`ifdef D_FF_ENABLE_EN
        en8 = 1'b1;
`endif
        push1(1'b1);
        push8(8'h3C);
        wait_until(91);
        check1("capture_90");
        check8("capture8_90");

        wait_until(130);
        d1 <= 1'b0;
        push1(1'b1);
        wait_until(131);
        check1("coincident_130");

        push1(1'b0);
        wait_until(151);
        check1("capture_150");

        wait_until(192);
        d1 = 1'b1;
        d8 = 8'h5A;
        push1(1'b1);
        wait_until(211);
        check1("capture_210");

        // Mid-run reset: no effect until the 230 ns edge.
        wait_until(215);
        rst_n = 1'b0;
        push1(1'b1);
        wait_until(229);
        check1("reset_not_async");

        push1(1'b0);
        push8(8'hA5);
        wait_until(231);
        check1("midrun_reset_230");
        check8("midrun_reset8_230");

        wait_until(235);
        rst_n = 1'b1;
        push1(1'b0);
        wait_until(245);
        check1("hold_after_deassert_2");

        push1(1'b1);
        push8(8'h5A);
        wait_until(251);
        check1("resume_250");
        check8("resume8_250");

        wait_until(255);
        d1 = 1'b0;
        push1(1'b0);
        wait_until(271);
        check1("capture_270");

        wait_until(330);
        d1 <= 1'b1;
        push1(1'b0);
        wait_until(331);
        check1("coincident_330");

        push1(1'b1);
        wait_until(351);
        check1("capture_350");

        wait_until(415);
        d1 = 1'b0;
        push1(1'b0);
        wait_until(431);
        check1("capture_430");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
